// File: rtl/joint_cmd_watchdog.sv
// joint_cmd_watchdog
//
// Screens decoded joint commands from the UDP parser, clamps their targets
// and presents registered targets to the motor control loops. A watchdog
// drops the outputs to a safe idle (mode 0, targets 0) when the host stops
// sending fresh commands.
//
// Two-stage pipeline:
//   stage 1 : fields, accept/reject decision and clamped targets registered
//   stage 2 : outputs, counters, last_id, watchdog and state updated
//
// Ports:
//   c                 clock
//   rst               asynchronous active-high reset
//   en                enable; 0 holds the block idle and rejects commands
//   cmd_valid         one-cycle command strobe, fields valid in same cycle
//   mode              commanded mode
//   tgt_0..tgt_2      signed 32-bit targets
//   control_id        host sequence number
//   out_mode          mode applied to the control loops
//   out_tgt_0..2      clamped signed targets
//   out_valid         one-cycle pulse whenever the outputs update
//   timeout           high while in TIMEOUT
//   active            high while in ACTIVE
//   last_id           control_id of the last accepted command
//   accept_cnt        saturating count of accepted commands
//   reject_cnt        saturating count of rejected commands
module joint_cmd_watchdog #(
   parameter logic [23:0]        TIMEOUT_CYCLES = 24'd5000000,
   parameter logic [7:0]         MODE_MAX       = 8'd3,
   parameter logic signed [31:0] TGT_LIMIT      = 32'sd1000000
) (
   input  logic        c,
   input  logic        rst,
   input  logic        en,
   input  logic        cmd_valid,
   input  logic [7:0]  mode,
   input  logic [31:0] tgt_0,
   input  logic [31:0] tgt_1,
   input  logic [31:0] tgt_2,
   input  logic [31:0] control_id,
   output logic [7:0]  out_mode,
   output logic [31:0] out_tgt_0,
   output logic [31:0] out_tgt_1,
   output logic [31:0] out_tgt_2,
   output logic        out_valid,
   output logic        timeout,
   output logic        active,
   output logic [31:0] last_id,
   output logic [15:0] accept_cnt,
   output logic [15:0] reject_cnt
);

   typedef enum logic [1:0] {IDLE, ACTIVE, TIMEOUT} state_t;

   localparam logic [23:0] WD_LAST = TIMEOUT_CYCLES - 24'd1;

   state_t      state, state_next;
   logic [23:0] wd_cnt;
   logic        have_id;

   // stage 1 registers
   logic        s1_valid;
   logic        s1_accept;
   logic [7:0]  s1_mode;
   logic [31:0] s1_tgt_0, s1_tgt_1, s1_tgt_2;
   logic [31:0] s1_id;

   logic [31:0] ref_id;
   logic        ref_have;
   logic [31:0] id_diff;
   logic        cmd_accept;
   logic        s2_accept;
   logic        wd_expire;
   logic        out_nonzero;

   function automatic logic [31:0] clamp(input logic [31:0] t);
      if ($signed(t) > TGT_LIMIT)
         return TGT_LIMIT;
      else if ($signed(t) < -TGT_LIMIT)
         return -TGT_LIMIT;
      else
         return t;
   endfunction

   // Freshness is judged against the id that will be in force once stage 2
   // retires, so an accepted command still sitting in stage 1 is bypassed in.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      ref_id   = last_id;
      ref_have = have_id;
      if (s1_valid && s1_accept) begin
         ref_id   = s1_id;
         ref_have = 1'b1;
      end
      // Wrap-aware: the modular difference read as signed orders ids
      // correctly across the 0xFFFFFFFF -> 0 rollover.
      id_diff    = control_id - ref_id;
      cmd_accept = en && (mode <= MODE_MAX) && (!ref_have || ($signed(id_diff) > 0));
   end

   assign s2_accept   = s1_valid && s1_accept;
   assign out_nonzero = (out_mode != 8'd0) || (out_tgt_0 != 32'd0) ||
                        (out_tgt_1 != 32'd0) || (out_tgt_2 != 32'd0);

   // Next-state logic. Disable dominates; an accepted command retiring in
   // the expiry cycle beats the watchdog.
   always_comb begin
      state_next = state;
      wd_expire  = 1'b0;
      if (!en) begin
         state_next = IDLE;
      end else if (s2_accept) begin
         state_next = ACTIVE;
      end else if ((state == ACTIVE) && (wd_cnt == WD_LAST)) begin
         state_next = TIMEOUT;
         wd_expire  = 1'b1;
      end
   end

   always_ff @(posedge c or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   assign active  = (state == ACTIVE);
   assign timeout = (state == TIMEOUT);

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_accept  <= 1'b0;
         s1_mode    <= '0;
         s1_tgt_0   <= '0;
         s1_tgt_1   <= '0;
         s1_tgt_2   <= '0;
         s1_id      <= '0;
         out_mode   <= '0;
         out_tgt_0  <= '0;
         out_tgt_1  <= '0;
         out_tgt_2  <= '0;
         out_valid  <= 1'b0;
         last_id    <= '0;
         have_id    <= 1'b0;
         wd_cnt     <= '0;
         accept_cnt <= '0;
         reject_cnt <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         out_valid <= 1'b0;

         // Stage 1: commands arriving while disabled are never captured.
         s1_valid  <= cmd_valid && en;
         s1_accept <= cmd_accept;
         s1_mode   <= mode;
         s1_tgt_0  <= clamp(tgt_0);
         s1_tgt_1  <= clamp(tgt_1);
         s1_tgt_2  <= clamp(tgt_2);
         s1_id     <= control_id;

         // Stage 2
         if (!en) begin
            // Disable discards any stage-1 command uncounted; ids and
            // counters survive, freshness restarts.
            out_mode  <= '0;
            out_tgt_0 <= '0;
            out_tgt_1 <= '0;
            out_tgt_2 <= '0;
            out_valid <= out_nonzero;
            have_id   <= 1'b0;
            wd_cnt    <= '0;
         end else if (s2_accept) begin
            out_mode  <= s1_mode;
            out_tgt_0 <= s1_tgt_0;
            out_tgt_1 <= s1_tgt_1;
            out_tgt_2 <= s1_tgt_2;
            out_valid <= 1'b1;
            last_id   <= s1_id;
            have_id   <= 1'b1;
            wd_cnt    <= '0;
            if (accept_cnt != 16'hFFFF)
               accept_cnt <= accept_cnt + 16'd1;
         end else begin
            if (s1_valid && (reject_cnt != 16'hFFFF))
               reject_cnt <= reject_cnt + 16'd1;
            if (wd_expire) begin
               out_mode  <= '0;
               out_tgt_0 <= '0;
               out_tgt_1 <= '0;
               out_tgt_2 <= '0;
               out_valid <= 1'b1;
               have_id   <= 1'b0;
               wd_cnt    <= '0;
            end else if (state == ACTIVE) begin
               wd_cnt <= wd_cnt + 24'd1;
            end else begin
               wd_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_joint_cmd_watchdog.sv
// Directed bench for joint_cmd_watchdog with a 16-cycle watchdog.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_joint_cmd_watchdog;

   logic        c = 1'b0;
   logic        rst;
   logic        en;
   logic        cmd_valid;
   logic [7:0]  mode;
   logic [31:0] tgt_0, tgt_1, tgt_2, control_id;
   logic [7:0]  out_mode;
   logic [31:0] out_tgt_0, out_tgt_1, out_tgt_2;
   logic        out_valid, timeout, active;
   logic [31:0] last_id;
   logic [15:0] accept_cnt, reject_cnt;

   int checks = 0;
   int errors = 0;
   int ov_cnt = 0;
   int ovb, acc0, rej0;

   joint_cmd_watchdog #(
      .TIMEOUT_CYCLES(24'd16),
      .MODE_MAX      (8'd3),
      .TGT_LIMIT     (32'sd1000000)
   ) dut (
      .c         (c),
      .rst       (rst),
      .en        (en),
      .cmd_valid (cmd_valid),
      .mode      (mode),
      .tgt_0     (tgt_0),
      .tgt_1     (tgt_1),
      .tgt_2     (tgt_2),
      .control_id(control_id),
      .out_mode  (out_mode),
      .out_tgt_0 (out_tgt_0),
      .out_tgt_1 (out_tgt_1),
      .out_tgt_2 (out_tgt_2),
      .out_valid (out_valid),
      .timeout   (timeout),
      .active    (active),
      .last_id   (last_id),
      .accept_cnt(accept_cnt),
      .reject_cnt(reject_cnt)
   );

   always #5 c = ~c;

   // Count out_valid pulses just after each rising edge.
   always begin
      @(posedge c);
      #1;
      if (out_valid === 1'b1)
         ov_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL sim_time_limit: got expired expected finish");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called on a falling edge; presents one command for one cycle.
   task automatic send(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic [31:0] id);
      cmd_valid  = 1'b1;
      mode       = m;
      tgt_0      = a;
      tgt_1      = b;
      tgt_2      = d;
      control_id = id;
      @(negedge c);
      cmd_valid  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; cmd_valid = 1'b0; mode = '0;
      tgt_0 = '0; tgt_1 = '0; tgt_2 = '0; control_id = '0;
      @(negedge c);
      check("rst_out_mode", 32'(out_mode), 0);
      check("rst_out_tgt_0", out_tgt_0, 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_active", 32'(active), 0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_last_id", last_id, 0);
      check("rst_accept_cnt", 32'(accept_cnt), 0);
      check("rst_reject_cnt", 32'(reject_cnt), 0);
      rst = 1'b0;
      en  = 1'b1;
      @(negedge c);

      // Basic accept: out_valid two cycles after cmd_valid.
      send(8'd1, 100, 32'(-200), 0, 5);
      check("acc_stage1_quiet", 32'(out_valid), 0);
      @(negedge c);
      check("acc_out_valid", 32'(out_valid), 1);
      check("acc_out_mode", 32'(out_mode), 1);
      check("acc_tgt_0", out_tgt_0, 100);
      check("acc_tgt_1", out_tgt_1, 32'(-200));
      check("acc_tgt_2", out_tgt_2, 0);
      check("acc_active", 32'(active), 1);
      check("acc_accept_cnt", 32'(accept_cnt), 1);
      check("acc_last_id", last_id, 5);
      ovb = ov_cnt;

      // Duplicate id, older id, illegal mode.
      send(8'd1, 1, 1, 1, 5);
      send(8'd1, 1, 1, 1, 4);
      send(8'd7, 1, 1, 1, 6);
      @(negedge c);
      @(negedge c);
      check("rej_reject_cnt", 32'(reject_cnt), 3);
      check("rej_accept_cnt", 32'(accept_cnt), 1);
      check("rej_tgt_0_held", out_tgt_0, 100);
      check("rej_mode_held", 32'(out_mode), 1);
      check("rej_no_out_valid", ov_cnt, ovb);

      // Clamp.
      send(8'd2, 2000000, 32'(-2000000), 999999, 6);
      @(negedge c);
      check("clamp_out_valid", 32'(out_valid), 1);
      check("clamp_tgt_0", out_tgt_0, 1000000);
      check("clamp_tgt_1", out_tgt_1, 32'(-1000000));
      check("clamp_tgt_2", out_tgt_2, 999999);
      check("clamp_mode", 32'(out_mode), 2);
      ovb = ov_cnt;

      // Watchdog: expires exactly 16 cycles after the accepting edge.
      repeat (15) @(negedge c);
      check("wd_not_yet_timeout", 32'(timeout), 0);
      check("wd_not_yet_active", 32'(active), 1);
      @(negedge c);
      check("wd_timeout", 32'(timeout), 1);
      check("wd_active_low", 32'(active), 0);
      check("wd_out_valid", 32'(out_valid), 1);
      check("wd_mode_zero", 32'(out_mode), 0);
      check("wd_tgt_0_zero", out_tgt_0, 0);
      check("wd_tgt_1_zero", out_tgt_1, 0);
      @(negedge c);
      check("wd_single_pulse", ov_cnt, ovb + 1);
      check("wd_pulse_done", 32'(out_valid), 0);

      // Leave TIMEOUT with an otherwise stale id.
      send(8'd1, 7, 8, 9, 3);
      @(negedge c);
      check("exit_active", 32'(active), 1);
      check("exit_timeout_low", 32'(timeout), 0);
      check("exit_out_valid", 32'(out_valid), 1);
      check("exit_last_id", last_id, 3);
      check("exit_tgt_0", out_tgt_0, 7);

      // Disable briefly to restart freshness, then exercise id wrap.
      en = 1'b0;
      @(negedge c);
      check("dis_active_low", 32'(active), 0);
      check("dis_out_valid", 32'(out_valid), 1);
      check("dis_tgt_0_zero", out_tgt_0, 0);
      en = 1'b1;
      send(8'd0, 0, 0, 0, 32'hFFFF_FFFF);
      @(negedge c);
      check("wrap_seed_last_id", last_id, 32'hFFFF_FFFF);
      check("wrap_seed_active", 32'(active), 1);
      acc0 = int'(accept_cnt);
      rej0 = int'(reject_cnt);
      send(8'd1, 1, 1, 1, 1);
      send(8'd1, 2, 2, 2, 2);
      check("wrap_accept_last_id", last_id, 1);
      check("wrap_accept_valid", 32'(out_valid), 1);
      send(8'd1, 3, 3, 3, 2);
      check("b2b_first_last_id", last_id, 2);
      check("b2b_first_tgt_0", out_tgt_0, 2);
      @(negedge c);
      check("b2b_second_no_valid", 32'(out_valid), 0);
      check("b2b_accept_cnt", 32'(accept_cnt), acc0 + 2);
      check("b2b_reject_cnt", 32'(reject_cnt), rej0 + 1);
      check("b2b_tgt_0_held", out_tgt_0, 2);

      // Drop en while a command sits in stage 1.
      acc0 = int'(accept_cnt);
      rej0 = int'(reject_cnt);
      send(8'd2, 50, 50, 50, 10);
      en = 1'b0;
      @(negedge c);
      check("drop_accept_cnt", 32'(accept_cnt), acc0);
      check("drop_active", 32'(active), 0);
      check("drop_tgt_0_zero", out_tgt_0, 0);
      check("drop_mode_zero", 32'(out_mode), 0);
      check("drop_out_valid", 32'(out_valid), 1);
      check("drop_last_id_kept", last_id, 2);
      @(negedge c);
      check("drop_accept_cnt_after", 32'(accept_cnt), acc0);
      check("drop_reject_cnt_after", 32'(reject_cnt), rej0);
      check("drop_pulse_done", 32'(out_valid), 0);

      // Asynchronous reset mid-ACTIVE.
      en = 1'b1;
      send(8'd1, 5, 5, 5, 20);
      @(negedge c);
      check("pre_rst_active", 32'(active), 1);
      check("pre_rst_tgt_0", out_tgt_0, 5);
      #2;
      rst = 1'b1;
      #1;
      check("arst_tgt_0", out_tgt_0, 0);
      check("arst_mode", 32'(out_mode), 0);
      check("arst_active", 32'(active), 0);
      check("arst_last_id", last_id, 0);
      check("arst_accept_cnt", 32'(accept_cnt), 0);
      check("arst_reject_cnt", 32'(reject_cnt), 0);
      @(negedge c);
      rst = 1'b0;
      @(negedge c);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
